// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control FSM with memory ready handshake, wait-state timeout,
// sticky fault state and retired-instruction counter.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic [3:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;

  logic wait_state, wait_timeout, retire;
  logic pcwrite, branch;
  logic mr_raw, mw_raw, irw_raw, rw_raw;
  logic funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Wait counting applies only to the three states that own the memory port.
  assign wait_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
  assign wait_timeout = wait_state && !mem_ready && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d    = state_q;
    mr_raw     = 1'b0;
    mw_raw     = 1'b0;
    irw_raw    = 1'b0;
    rw_raw     = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mr_raw     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irw_raw    = mem_ready;
        pcwrite    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_FAULT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mr_raw = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw_raw   = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mw_raw = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        rw_raw  = 1'b1;
        regdst  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw_raw  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    // A completed access (mem_ready=1) never reaches here, so retire stays clean.
    if (wait_timeout) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (wait_state && !mem_ready && (state_d != S_FAULT))
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Strobes are gated by reset so nothing fires while reset is held low.
  assign memread  = mr_raw & reset;
  assign memwrite = mw_raw & reset;
  assign irwrite  = irw_raw & reset;
  assign regwrite = rw_raw & reset;
  assign pcen     = (pcwrite | (branch & zero)) & reset;

  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule
